// File: rtl/uart_tx_fifo.sv
// CSR-fed byte FIFO drained by an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
module uart_tx_fifo #(
    parameter int          DEPTH         = 16,
    parameter logic [11:0] FIFO_CSR_ADDR = 12'h050
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] prescaler,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic        rs1_zimm,
    input  logic [31:0] rs1_data,
    output logic [31:0] csr_data_out,
    output logic        tx,
    output logic        have_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, have_next_q;

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          next;

    logic [31:0]   operand;
    logic          push_req, push, pop, full, empty, ovf_set, ovf_clr;
    logic          unused_bits;

    assign operand  = rs1_zimm ? {27'b0, rs1_data[4:0]} : rs1_data;
    assign push_req = csr_enable && (csr_addr == FIFO_CSR_ADDR)
                      && (csr_op != 2'b11);
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = next && !empty;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = push_req && (csr_op == 2'b00) && operand[31];
    assign unused_bits = ^operand[30:8];

    assign have_next    = have_next_q;
    assign csr_data_out = (csr_addr == FIFO_CSR_ADDR)
                          ? {full, empty, ovf_q, 13'b0, 16'(count_q)}
                          : 32'b0;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Byte storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= operand[7:0];
    end

    // FIFO pointers, count, sticky overflow and registered non-empty flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            have_next_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            have_next_q <= (count_d != '0);
            if (ovf_set) ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Transmitter state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Transmitter next state, pop pulse and serial output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        next    = 1'b0;
        tx      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (have_next_q) begin
                    next    = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    cnt_d   = prescaler;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = prescaler;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                tx = data_q[bit_q];
                if (cnt_q == '0) begin
                    cnt_d = prescaler;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx = ^data_q;
                if (cnt_q == '0) begin
                    cnt_d   = prescaler;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (have_next_q) begin
                        next    = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        cnt_d   = prescaler;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
// Covers reset, back-to-back frames, prescaling, overflow and mid-frame reset.
module tb_uart_tx_fifo;
    localparam int          DEPTH = 16;
    localparam logic [11:0] ADDR  = 12'h050;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] prescaler = 32'd0;
    logic        csr_enable = 1'b0;
    logic [11:0] csr_addr = ADDR;
    logic [1:0]  csr_op = 2'b11;
    logic        rs1_zimm = 1'b0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] csr_data_out;
    logic        tx;
    logic        have_next;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .FIFO_CSR_ADDR(ADDR)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .prescaler(prescaler),
        .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
        .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
        .csr_data_out(csr_data_out), .tx(tx), .have_next(have_next)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_start(input logic [31:0] d, input logic [1:0] op);
        csr_enable = 1'b1;
        csr_addr   = ADDR;
        csr_op     = op;
        rs1_zimm   = 1'b0;
        rs1_data   = d;
    endtask

    task automatic idle_bus();
        csr_enable = 1'b0;
        csr_addr   = ADDR;
        csr_op     = 2'b11;
        rs1_data   = 32'd0;
    endtask

    task automatic wr(input logic [31:0] d);
        push_start(d, 2'b00);
        step();
        idle_bus();
    endtask

    // Expected tx level at position k of the frame carrying byte b.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Independent receiver: finds a start bit, samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int t = 0;
        int n;
        ok = 1'b1;
        b  = 8'h00;
        n  = int'(prescaler) + 1;
        while (tx !== 1'b0 && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) begin
            ok = 1'b0;
            return;
        end
        repeat (n / 2) step();
        for (int i = 0; i < 8; i++) begin
            repeat (n) step();
            b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (n) step();
        if (tx !== ^b) ok = 1'b0;
`endif
        repeat (n) step();
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes4 [4];
        logic [7:0] got [$];
        logic [7:0] rb;
        logic       rok;
        logic       quiet;
        int         rx_bad;
        logic       e;

        bytes4[0] = 8'hDE; bytes4[1] = 8'hAD;
        bytes4[2] = 8'hBE; bytes4[3] = 8'hEF;

        // Reset one cycle, then idle for 100 cycles.
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_hn", 32'(have_next), 32'd0);
            chk("idle_st", csr_data_out, 32'h4000_0000);
            step();
        end
        csr_addr = 12'h051;
        #1;
        chk("other_addr", csr_data_out, 32'd0);
        csr_addr = ADDR;

        // Four back-to-back frames at one cycle per bit.
        prescaler = 32'd0;
        push_start(32'(bytes4[0]), 2'b00);
        step();
        for (int i = 0; i < 4 * FL + 2; i++) begin
            if (i == 0 || i > 4 * FL) e = 1'b1;
            else e = fbit(bytes4[(i-1)/FL], (i-1) % FL);
            chk($sformatf("b2b_tx%0d", i), 32'(tx), 32'(e));
            if (i < 3) push_start(32'(bytes4[i+1]), 2'b00);
            else idle_bus();
            step();
        end
        chk("b2b_hn", 32'(have_next), 32'd0);
        chk("b2b_st", csr_data_out, 32'h4000_0000);

        // Single 0x55 with each bit held four cycles.
        prescaler = 32'd3;
        wr(32'h55);
        for (int i = 0; i < 4 * FL + 2; i++) begin
            if (i == 0 || i > 4 * FL) e = 1'b1;
            else e = fbit(8'h55, (i-1) / 4);
            chk($sformatf("p3_tx%0d", i), 32'(tx), 32'(e));
            step();
        end

        // Overflow: DEPTH+2 writes while first byte is in flight.
        rx_bad = 0;
        fork
            begin : writer
                for (int k = 0; k < DEPTH + 2; k++) begin
                    push_start(32'h30 + 32'(k), 2'(k % 3));
                    step();
                end
                idle_bus();
                chk("ovf_st_full", csr_data_out, 32'hA000_0010);
            end
            begin : reader
                logic [7:0] b;
                logic       ok;
                for (int k = 0; k < DEPTH + 1; k++) begin
                    rx_byte(b, ok);
                    if (!ok) rx_bad++;
                    else got.push_back(b);
                end
            end
        join
        chk("ovf_rx_bad", 32'(rx_bad), 32'd0);
        chk("ovf_rx_n", 32'(got.size()), 32'(DEPTH + 1));
        foreach (got[i])
            chk($sformatf("ovf_rx%0d", i), 32'(got[i]), 32'h30 + 32'(i));
        quiet = 1'b1;
        repeat (60) begin
            step();
            if (tx !== 1'b1) quiet = 1'b0;
        end
        chk("ovf_no_extra", 32'(quiet), 32'd1);
        chk("ovf_st_empty", csr_data_out, 32'h6000_0000);
        wr(32'h8000_0000);
        chk("ovf_clr_st", csr_data_out, 32'h0000_0001);
        chk("ovf_clr_bit", 32'(csr_data_out[29]), 32'd0);
        rx_byte(rb, rok);
        chk("clr_rx_ok", 32'(rok), 32'd1);
        chk("clr_rx", 32'(rb), 32'h00);
        repeat (10) step();

        // Reset in the middle of the data bits of 0xA5.
        wr(32'hA5);
        wr(32'h01);
        wr(32'h02);
        wr(32'h03);
        repeat (6) step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_hn", 32'(have_next), 32'd0);
        chk("rst_st", csr_data_out, 32'h4000_0000);
        quiet = 1'b1;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || have_next !== 1'b0) quiet = 1'b0;
        end
        chk("rst_quiet", 32'(quiet), 32'd1);
        wr(32'h0F);
        rx_byte(rb, rok);
        chk("post_rst_ok", 32'(rok), 32'd1);
        chk("post_rst_rx", 32'(rb), 32'h0F);
        repeat (10) step();

`ifdef UART_TX_PARITY_EN
        begin : parity
            logic [10:0] pv;
            pv = 11'b110_0000_1110;
            prescaler = 32'd0;
            wr(32'h07);
            for (int i = 0; i < 13; i++) begin
                if (i == 0 || i == 12) e = 1'b1;
                else e = pv[i-1];
                chk($sformatf("par_tx%0d", i), 32'(tx), 32'(e));
                step();
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
